// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundle of the four requester channels (fetch, LSB load, ROB store, ROB IO
//   load) and the byte-wide RAM pins served by mem_arbiter.
//
//   modport slave  : the arbiter side (takes requests, drives the RAM pins).
//   modport master : the requester / RAM side.
//
//   Parameters:
//     ADDR_W  address width of every request address and of mem_a.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Instruction fetch: always a 4-byte read.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  // LSB load: 1, 2 or 4 bytes, zero-extended.
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_size;
  logic              ld_done;
  logic [31:0]       ld_data;

  // ROB committed store: 1, 2 or 4 low bytes of st_data.
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [2:0]        st_size;
  logic [31:0]       st_data;
  logic              st_done;

  // ROB IO load: a single byte.
  logic              io_req;
  logic [ADDR_W-1:0] io_addr;
  logic              io_done;
  logic [31:0]       io_data;

  // Registered byte-wide RAM.
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  if_req, if_addr,
    input  ld_req, ld_addr, ld_size,
    input  st_req, st_addr, st_size, st_data,
    input  io_req, io_addr,
    input  mem_din,
    output if_done, if_data,
    output ld_done, ld_data,
    output st_done,
    output io_done, io_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr,
    output ld_req, ld_addr, ld_size,
    output st_req, st_addr, st_size, st_data,
    output io_req, io_addr,
    output mem_din,
    input  if_done, if_data,
    input  ld_done, ld_data,
    input  st_done,
    input  io_done, io_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Owns the single byte-wide RAM port and shares it between instruction
//   fetch, LSB loads, ROB committed stores and ROB IO loads. Each granted
//   request becomes 1..4 sequential byte accesses; read bytes are assembled
//   little-endian into a zero-extended 32-bit word and a one-cycle done pulse
//   is returned to the owner.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     rdy               global enable; low freezes every register, gates mem_wr
//     clear             misprediction flush: aborts reads, blocks a new grant
//     io_buffer_full    IO output buffer full; stalls a store to the IO region
//     bus (slave)       requester channels and RAM pins (see mem_arbiter_if)
//     stat_busy_cycles, stat_io_stall_cycles
//                       saturating statistics, only with MEM_ARBITER_STAT_EN
//
//   Parameters:
//     ADDR_W  address width; must match the ADDR_W of the connected interface
//     IO_HI   value of addr[17:16] that marks the IO region
//
//   Build option:
//     MEM_ARBITER_STAT_EN  adds the two statistics counters and their ports.
//
//   Timing (grant edge E0, N bytes):
//     read : mem_a = addr+i after Ei, byte i captured at E(i+2),
//            done/data registered at E(N+1)
//     write: mem_wr/mem_a/mem_dout for byte i set at Ei, st_done at EN
//   Every transaction ends with one DONE cycle in which nothing is granted,
//   so a requester dropping req on done is never granted twice.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         clear,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STAT_EN
  ,
  output logic [31:0]  stat_busy_cycles,
  output logic [31:0]  stat_io_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {REQ_IF, REQ_LD, REQ_IO, REQ_ST} req_t;

  // Sizes other than 1 and 2 are treated as a full word.
  function automatic logic [2:0] decode_len(input logic [2:0] size);
    case (size)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t            state, state_next;

  // Latched transaction.
  req_t              kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        len_q;
  logic [31:0]       wdata_q;
  logic [2:0]        cnt;
  logic [31:0]       rd_buf;
  logic              mem_wr_q;

  // Grant decode.
  logic              st_blocked;
  logic              any_req;
  logic              gnt;
  req_t              g_kind;
  logic [ADDR_W-1:0] g_addr;
  logic [2:0]        g_len;

  // Sequencing helpers.
  logic [2:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_step;
  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;
  logic [7:0]        byte_in;
  logic [31:0]       rd_next;

  // RAM read-data hold across a rdy-low stretch.
  logic              stall_q;
  logic [7:0]        din_hold;

  // ---------------------------------------------------------------------------
  // Grant: fixed priority st > io > ld > if. A store to the IO region while the
  // IO buffer is full blocks everyone below it so commit order is preserved.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    st_blocked = bus.st_req && (bus.st_addr[17:16] == IO_HI) && io_buffer_full;
    any_req    = bus.st_req || bus.io_req || bus.ld_req || bus.if_req;
    gnt        = (state == S_IDLE) && !clear && !st_blocked && any_req;
    g_kind     = REQ_IF;
    g_addr     = bus.if_addr;
    g_len      = 3'd4;
    if (bus.st_req) begin
      g_kind = REQ_ST;
      g_addr = bus.st_addr;
      g_len  = decode_len(bus.st_size);
    end else if (bus.io_req) begin
      g_kind = REQ_IO;
      g_addr = bus.io_addr;
      g_len  = 3'd1;
    end else if (bus.ld_req) begin
      g_kind = REQ_LD;
      g_addr = bus.ld_addr;
      g_len  = decode_len(bus.ld_size);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (gnt) begin
          state_next = (g_kind == REQ_ST) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (clear) begin
          state_next = S_IDLE;
        end else if (cnt == len_q) begin
          state_next = S_DONE;
        end
      end
      S_WRITE: begin
        // A committed store is never aborted by clear.
        if (cnt_inc >= len_q) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // The RAM keeps running while rdy is low, so mem_din at the resume edge
  // belongs to the held address rather than the one the sequence expects.
  // The byte that was due at the first frozen edge is kept and substituted
  // at the resume edge; later bytes line up again by themselves.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= 1'b0;
      din_hold <= 8'h00;
    end else begin
      stall_q <= !rdy;
      if (!rdy && !stall_q) begin
        din_hold <= bus.mem_din;
      end
    end
  end

  assign byte_in   = stall_q ? din_hold : bus.mem_din;
  assign cnt_inc   = cnt + 3'd1;
  assign addr_step = addr_q + ADDR_W'(cnt_inc);
  assign rd_idx    = 2'(cnt - 3'd1);
  assign wr_idx    = cnt_inc[1:0];

  // Read buffer with the byte captured at this edge merged in.
  always_comb begin
    rd_next                  = rd_buf;
    rd_next[8*rd_idx +: 8]   = byte_in;
  end

  // ---------------------------------------------------------------------------
  // Datapath. cnt equals k-1 at edge Ek of a transaction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only flops live here (no memory arrays), so all of them are reset;
    // the outputs must read as 0 from the first cycle.
    if (!rst_n) begin
      kind_q       <= REQ_IF;
      addr_q       <= '0;
      len_q        <= 3'd0;
      wdata_q      <= 32'h0;
      cnt          <= 3'd0;
      rd_buf       <= 32'h0;
      mem_wr_q     <= 1'b0;
      bus.mem_a    <= '0;
      bus.mem_dout <= 8'h00;
      bus.if_done  <= 1'b0;
      bus.ld_done  <= 1'b0;
      bus.io_done  <= 1'b0;
      bus.st_done  <= 1'b0;
      bus.if_data  <= 32'h0;
      bus.ld_data  <= 32'h0;
      bus.io_data  <= 32'h0;
    end else if (rdy) begin
      bus.if_done <= 1'b0;
      bus.ld_done <= 1'b0;
      bus.io_done <= 1'b0;
      bus.st_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt) begin
            kind_q    <= g_kind;
            addr_q    <= g_addr;
            len_q     <= g_len;
            wdata_q   <= bus.st_data;
            cnt       <= 3'd0;
            rd_buf    <= 32'h0;
            bus.mem_a <= g_addr;
            if (g_kind == REQ_ST) begin
              mem_wr_q     <= 1'b1;
              bus.mem_dout <= bus.st_data[7:0];
            end
          end
        end
        S_READ: begin
          if (clear) begin
            cnt <= 3'd0;
          end else begin
            // No byte is due at E1: the first address is only now in the RAM.
            if (cnt != 3'd0) begin
              rd_buf <= rd_next;
            end
            if (cnt_inc < len_q) begin
              bus.mem_a <= addr_step;
            end
            if (cnt == len_q) begin
              cnt <= 3'd0;
              case (kind_q)
                REQ_LD: begin
                  bus.ld_done <= 1'b1;
                  bus.ld_data <= rd_next;
                end
                REQ_IO: begin
                  bus.io_done <= 1'b1;
                  bus.io_data <= rd_next;
                end
                default: begin
                  bus.if_done <= 1'b1;
                  bus.if_data <= rd_next;
                end
              endcase
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_WRITE: begin
          if (cnt_inc < len_q) begin
            bus.mem_a    <= addr_step;
            bus.mem_dout <= wdata_q[8*wr_idx +: 8];
            cnt          <= cnt_inc;
          end else begin
            mem_wr_q    <= 1'b0;
            bus.st_done <= 1'b1;
            cnt         <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // A frozen cycle must never repeat a write into the RAM.
  assign bus.mem_wr = mem_wr_q && rdy;

`ifdef MEM_ARBITER_STAT_EN
  // ---------------------------------------------------------------------------
  // Statistics: saturating counters of busy cycles and IO-stalled IDLE cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_busy_cycles     <= 32'h0;
      stat_io_stall_cycles <= 32'h0;
    end else if (rdy) begin
      if ((state != S_IDLE) && (stat_busy_cycles != 32'hFFFF_FFFF)) begin
        stat_busy_cycles <= stat_busy_cycles + 32'd1;
      end
      if ((state == S_IDLE) && st_blocked &&
          (stat_io_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_io_stall_cycles <= stat_io_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A registered byte-wide RAM model answers
//   reads from a fixed content table; writes are counted. Stimulus is driven
//   and outputs are sampled on the falling clock edge. "cycle k" below means
//   the falling edge after the k-th rising edge, counting the grant edge as 1.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic clear;
  logic io_buffer_full;
  int   n_cmp;
  int   n_bad;
  int   wr_count;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // RAM contents (only the low 12 address bits select a byte).
  function automatic logic [7:0] rom(input logic [11:0] a);
    case (a)
      12'h100: return 8'h13;
      12'h101: return 8'h00;
      12'h102: return 8'h00;
      12'h103: return 8'h93;
      12'h200: return 8'h5A;
      12'h201: return 8'hC3;
      12'h202: return 8'h11;
      12'h203: return 8'h22;
      12'h205: return 8'h7F;
      12'h004: return 8'hE7;
      default: return {a[3:0], a[7:4]} ^ 8'h5C;
    endcase
  endfunction

  // Registered RAM: data for an address appears the cycle after it.
  always @(posedge clk) begin
    bus.mem_din <= rom(bus.mem_a[11:0]);
    if (bus.mem_wr) wr_count <= wr_count + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_all();
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    bus.st_req = 1'b0;
    bus.io_req = 1'b0;
  endtask

  // Waits for any done pulse; seen = {st, io, ld, if}, 0 on timeout.
  task automatic wait_done(input int limit, output logic [3:0] seen, output int waited);
    seen   = 4'b0000;
    waited = 0;
    while (seen == 4'b0000 && waited < limit) begin
      @(negedge clk);
      waited++;
      seen = {bus.st_done, bus.io_done, bus.ld_done, bus.if_done};
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.if_done, bus.ld_done, bus.io_done, bus.st_done, bus.mem_wr} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.if_done, bus.ld_done, bus.io_done, bus.st_done, bus.mem_wr});
    end
    n_cmp++;
    if ({bus.mem_a, bus.mem_dout} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_mem: got a=%h dout=%h expected 0", bus.mem_a, bus.mem_dout);
    end
    n_cmp++;
    if ({bus.if_data, bus.ld_data, bus.io_data} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h expected 0", bus.if_data, bus.ld_data, bus.io_data);
    end
  endtask

  task automatic test_fetch();
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n_cmp++;
      if (bus.mem_a !== 32'h100 + 32'(i) || bus.if_done !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_addr%0d: got a=%h done=%b expected a=%h done=0",
                 i, bus.mem_a, bus.if_done, 32'h100 + 32'(i));
      end
    end
    cyc(1);
    n_cmp++;
    if (bus.if_done !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_early_done: got %b expected 0", bus.if_done);
    end
    cyc(1);
    n_cmp++;
    if (bus.if_done !== 1'b1 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL fetch_done: got done=%b data=%h expected done=1 data=93000013",
               bus.if_done, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(1);
    n_cmp++;
    if (bus.if_done !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_pulse_width: got %b expected 0", bus.if_done);
    end
    cyc(2);
  endtask

  task automatic test_byte_load();
    bus.ld_addr = 32'h205;
    bus.ld_size = 3'd1;
    bus.ld_req  = 1'b1;
    cyc(1);
    n_cmp++;
    if (bus.mem_a !== 32'h205) begin
      n_bad++;
      $display("FAIL ldb_addr: got %h expected 00000205", bus.mem_a);
    end
    cyc(1);
    n_cmp++;
    if (bus.ld_done !== 1'b0) begin
      n_bad++;
      $display("FAIL ldb_early_done: got %b expected 0", bus.ld_done);
    end
    cyc(1);
    n_cmp++;
    if (bus.ld_done !== 1'b1 || bus.ld_data !== 32'h0000_007F) begin
      n_bad++;
      $display("FAIL ldb_done: got done=%b data=%h expected done=1 data=0000007f",
               bus.ld_done, bus.ld_data);
    end
    bus.ld_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_invalid_size();
    logic [3:0] seen;
    int         waited;
    bus.ld_addr = 32'h200;
    bus.ld_size = 3'd3;
    bus.ld_req  = 1'b1;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0010 || waited != 6 || bus.ld_data !== 32'h2211_C35A) begin
      n_bad++;
      $display("FAIL ld_size3: got seen=%b cycles=%0d data=%h expected 0010 6 2211c35a",
               seen, waited, bus.ld_data);
    end
    bus.ld_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_io_load();
    logic [3:0] seen;
    int         waited;
    bus.io_addr = 32'h0003_0004;
    bus.io_req  = 1'b1;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0100 || waited != 3 || bus.io_data !== 32'h0000_00E7) begin
      n_bad++;
      $display("FAIL io_load: got seen=%b cycles=%0d data=%h expected 0100 3 000000e7",
               seen, waited, bus.io_data);
    end
    bus.io_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_priority();
    logic [3:0] seen;
    int         waited;
    bus.if_addr = 32'h100;
    bus.ld_addr = 32'h200;
    bus.ld_size = 3'd2;
    bus.st_addr = 32'h300;
    bus.st_size = 3'd1;
    bus.st_data = 32'h0000_00AB;
    bus.if_req  = 1'b1;
    bus.ld_req  = 1'b1;
    bus.st_req  = 1'b1;
    cyc(1);
    n_cmp++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h300, 8'hAB}) begin
      n_bad++;
      $display("FAIL prio_store_write: got wr=%b a=%h dout=%h expected 1 00000300 ab",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    cyc(1);
    n_cmp++;
    if (bus.st_done !== 1'b1 || bus.mem_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_store_done: got done=%b wr=%b expected 1 0", bus.st_done, bus.mem_wr);
    end
    bus.st_req = 1'b0;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0010 || bus.ld_data !== 32'h0000_C35A) begin
      n_bad++;
      $display("FAIL prio_load: got seen=%b data=%h expected 0010 0000c35a", seen, bus.ld_data);
    end
    bus.ld_req = 1'b0;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0001 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL prio_fetch: got seen=%b data=%h expected 0001 93000013", seen, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_io_stall();
    logic [3:0] seen;
    int         waited;
    int         wc;
    bus.st_addr    = 32'h0003_0000;
    bus.st_size    = 3'd1;
    bus.st_data    = 32'h0000_0042;
    bus.if_addr    = 32'h100;
    io_buffer_full = 1'b1;
    bus.st_req     = 1'b1;
    bus.if_req     = 1'b1;
    wc             = wr_count;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_cmp++;
      if ({bus.mem_wr, bus.if_done, bus.st_done} !== 3'b000) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: got wr=%b if_done=%b st_done=%b expected 000",
                 i, bus.mem_wr, bus.if_done, bus.st_done);
      end
    end
    n_cmp++;
    if (wr_count != wc) begin
      n_bad++;
      $display("FAIL stall_writes: got %0d expected 0", wr_count - wc);
    end
    io_buffer_full = 1'b0;
    cyc(1);
    n_cmp++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h0003_0000, 8'h42}) begin
      n_bad++;
      $display("FAIL stall_release: got wr=%b a=%h dout=%h expected 1 00030000 42",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    cyc(1);
    n_cmp++;
    if (bus.st_done !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_st_done: got %b expected 1", bus.st_done);
    end
    bus.st_req = 1'b0;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0001 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL stall_fetch_after: got seen=%b data=%h expected 0001 93000013",
               seen, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_clear_read();
    logic [3:0] seen;
    int         waited;
    bus.ld_addr = 32'h400;
    bus.ld_size = 3'd4;
    bus.ld_req  = 1'b1;
    cyc(2);
    n_cmp++;
    if (bus.mem_a !== 32'h401) begin
      n_bad++;
      $display("FAIL clr_rd_pre: got a=%h expected 00000401", bus.mem_a);
    end
    clear = 1'b1;
    cyc(1);
    n_cmp++;
    if (bus.mem_a !== 32'h401 || bus.ld_done !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_rd_abort: got a=%h done=%b expected 00000401 0", bus.mem_a, bus.ld_done);
    end
    clear       = 1'b0;
    bus.ld_req  = 1'b0;
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    cyc(1);
    n_cmp++;
    if (bus.mem_a !== 32'h100) begin
      n_bad++;
      $display("FAIL clr_rd_idle: got a=%h expected 00000100", bus.mem_a);
    end
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0001 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL clr_rd_next: got seen=%b data=%h expected 0001 93000013", seen, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_clear_write();
    logic [31:0] d;
    int          wc;
    d           = 32'hDDCC_BBAA;
    bus.st_addr = 32'h500;
    bus.st_size = 3'd4;
    bus.st_data = d;
    bus.st_req  = 1'b1;
    wc          = wr_count;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n_cmp++;
      if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h500 + 32'(i), d[8*i +: 8]}) begin
        n_bad++;
        $display("FAIL clr_wr_byte%0d: got wr=%b a=%h dout=%h expected 1 %h %h",
                 i, bus.mem_wr, bus.mem_a, bus.mem_dout, 32'h500 + 32'(i), d[8*i +: 8]);
      end
      clear = (i == 1);
    end
    clear = 1'b0;
    cyc(1);
    n_cmp++;
    if (bus.st_done !== 1'b1 || bus.mem_wr !== 1'b0 || wr_count - wc != 4) begin
      n_bad++;
      $display("FAIL clr_wr_done: got done=%b wr=%b writes=%0d expected 1 0 4",
               bus.st_done, bus.mem_wr, wr_count - wc);
    end
    bus.st_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_async_reset();
    logic [3:0] seen;
    int         waited;
    bus.st_addr = 32'h600;
    bus.st_size = 3'd4;
    bus.st_data = 32'h1122_3344;
    bus.st_req  = 1'b1;
    cyc(2);
    n_cmp++;
    if (bus.mem_wr !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got wr=%b expected 1", bus.mem_wr);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    bus.st_req = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    wait_done(40, seen, waited);
    n_cmp++;
    if (seen !== 4'b0001 || waited != 6 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL arst_fetch: got seen=%b cycles=%0d data=%h expected 0001 6 93000013",
               seen, waited, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_rdy_stall();
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    cyc(2);
    n_cmp++;
    if (bus.mem_a !== 32'h101) begin
      n_bad++;
      $display("FAIL rdy_pre: got a=%h expected 00000101", bus.mem_a);
    end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_cmp++;
      if ({bus.mem_a, bus.mem_wr, bus.if_done} !== {32'h101, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL rdy_hold%0d: got a=%h wr=%b done=%b expected 00000101 0 0",
                 i, bus.mem_a, bus.mem_wr, bus.if_done);
      end
    end
    rdy = 1'b1;
    cyc(1);
    n_cmp++;
    if (bus.mem_a !== 32'h102 || bus.if_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rdy_resume: got a=%h done=%b expected 00000102 0", bus.mem_a, bus.if_done);
    end
    cyc(2);
    n_cmp++;
    if (bus.if_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rdy_early_done: got %b expected 0", bus.if_done);
    end
    cyc(1);
    n_cmp++;
    if (bus.if_done !== 1'b1 || bus.if_data !== 32'h9300_0013) begin
      n_bad++;
      $display("FAIL rdy_done: got done=%b data=%h expected 1 93000013", bus.if_done, bus.if_data);
    end
    bus.if_req = 1'b0;
    cyc(2);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    rdy            = 1'b1;
    clear          = 1'b0;
    io_buffer_full = 1'b0;
    drop_all();
    bus.if_addr    = '0;
    bus.ld_addr    = '0;
    bus.ld_size    = 3'd4;
    bus.st_addr    = '0;
    bus.st_size    = 3'd4;
    bus.st_data    = '0;
    bus.io_addr    = '0;
    cyc(2);
    test_reset();
    rst_n = 1'b1;
    cyc(2);
    test_fetch();
    test_byte_load();
    test_invalid_size();
    test_io_load();
    test_priority();
    test_io_stall();
    test_clear_read();
    test_clear_write();
    test_async_reset();
    test_rdy_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between four requesters: instruction fetch, LSB load, ROB committed store, and ROB IO load.
- Each request is split into 1–4 sequential byte accesses; the block assembles or splits 32-bit data and pulses a per-requester done.
- Sits between the fetch unit, LSB, ROB and the top-level RAM/IO pins.
- Replaces ad-hoc memory sequencing scattered in the ROB and LSB.

Parameters:
- ADDR_W, 32, address width of requests and mem_a.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region (0x30000+).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; low freezes the block.
- clear  in  1  misprediction flush.
- if_req  in  1  fetch request (level, held until if_done).
- if_addr  in  ADDR_W  fetch address; always 4 bytes.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word.
- ld_req  in  1  LSB load request.
- ld_addr  in  ADDR_W  load address.
- ld_size  in  3  load size in bytes: 1, 2 or 4.
- ld_done  out  1  one-cycle pulse; ld_data valid.
- ld_data  out  32  load data, zero-extended.
- st_req  in  1  ROB store request.
- st_addr  in  ADDR_W  store address.
- st_size  in  3  store size in bytes: 1, 2 or 4.
- st_data  in  32  store data; low bytes used.
- st_done  out  1  one-cycle pulse; store finished.
- io_req  in  1  ROB IO load request; 1 byte at io_addr.
- io_addr  in  ADDR_W  IO load address.
- io_done  out  1  one-cycle pulse; io_data valid.
- io_data  out  32  IO byte, zero-extended.
- mem_din  in  8  RAM read byte, registered RAM: data appears the cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  IO output buffer full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, byte counter=0.
  - all done pulses, mem_wr, mem_dout, mem_a = 0.
  - if_data, ld_data, io_data = 0.
- States:
  - IDLE: grant evaluated.
  - READ and WRITE: byte sequencing.
  - DONE: one cycle, no grant, mem_wr=0.
  - DONE always → IDLE.
- Grant (in IDLE, at a rdy edge):
  - Fixed priority: st > io > ld > if.
  - Requester's addr, size and data are latched at the grant edge.
  - Non-preemptive.
  - Requesters must drop req in the cycle they see done. DONE guarantees no regrant from a stale req.
- Read of N bytes (grant edge = E0):
  - mem_a = addr+i in the cycle after edge Ei, for i = 0..N-1.
  - Byte i is sampled from mem_din at edge Ei+2 into bits [8i+7:8i], little-endian.
  - done and data are registered at edge E(N+1) and high for exactly one cycle.
  - Fetch: done 5 edges after grant. Byte load: 2 edges.
  - Unused upper bits are 0.
- Write of N bytes:
  - From E0 to E(N-1): mem_wr=1, mem_a=addr+i, mem_dout=st_data[8i+7:8i].
  - At EN: mem_wr=0 and st_done pulses.
- IO stall:
  - If the winning request is a store with addr[17:16]==IO_HI and io_buffer_full=1, nothing is granted (lower requesters included).
  - Preserves commit order.
  - Re-evaluated every IDLE cycle.
- Address arithmetic: addr+i computed at ADDR_W width, wraps modulo 2^ADDR_W.
- clear:
  - During READ (if/ld/io): abort at the next edge → IDLE, no done, mem_wr=0.
  - During WRITE: ignored; a committed store always completes and pulses st_done.
  - clear in IDLE: no grant that cycle.
- rdy low: all registers hold; mem_wr output gated to 0.
- Invalid size (not 1/2/4): treated as 4.
- Reset mid-transaction: immediate return to IDLE; no done issued.

Optional Feature:
- Macro: MEM_ARBITER_STAT_EN.
- Defined: adds outputs stat_busy_cycles[31:0] and stat_io_stall_cycles[31:0].
  - stat_busy_cycles counts rdy cycles not in IDLE.
  - stat_io_stall_cycles counts IDLE cycles blocked by io_buffer_full.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 00 00 93 → mem_a 0x100..0x103 on consecutive cycles; if_done 5 edges after grant; if_data=0x93000013.
- Priority: if_req, ld_req (0x200, size 2) and st_req (0x300, size 1, data 0xAB) all asserted in the same cycle → store first (mem_wr=1, mem_a=0x300, dout=0xAB, st_done after 1 edge), then ld (ld_data=0x0000xxyy), then fetch.
- IO stall: st_req to 0x30000 with io_buffer_full=1 for 10 cycles, if_req also high → no mem_wr and no if grant for 10 cycles; store granted at the first cycle full=0.
- clear mid-read: ld 4 bytes at 0x400, clear at edge E2 → no ld_done, state IDLE next cycle. The same pattern during a 4-byte store → all 4 writes occur and st_done pulses.
- Async reset: drop rst_n mid-WRITE between edges → mem_wr=0 immediately, all outputs 0; after release a new fetch completes normally.
- rdy low for 3 cycles during a fetch → mem_wr stays 0, counter holds; if_data still correct; done delayed by exactly 3 cycles.
